// File: rtl/sha_nonce_result_checker_pkg.sv
// Shared SHA types: hash state, byte-reverse helper and nonce-checker FSM states.
package sha_nonce_result_checker_pkg;

   typedef struct packed {
      logic [31:0] a, b, c, d, e, f, g, h;
   } HashState;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } checker_state_t;

   localparam int unsigned HASH_W     = 256;
   localparam int unsigned CHUNK_W    = 64;
   localparam int unsigned NUM_CHUNKS = HASH_W / CHUNK_W;

   // Bitcoin compares the digest as a little-endian integer.
   function automatic logic [HASH_W-1:0] byte_reverse(input HashState hs);
      logic [HASH_W-1:0] x;
      logic [HASH_W-1:0] y;
      x = hs;
      y = '0;
      for (int unsigned i = 0; i < HASH_W / 8; i++) begin
         y[8*i +: 8] = x[8*(HASH_W/8 - 1 - i) +: 8];
      end
      return y;
   endfunction

endpackage

// File: rtl/sha_nonce_result_checker_fifo.sv
// Found-nonce FIFO: 32-bit entries, extra pointer bit distinguishes full from empty.
module nonce_result_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic [31:0] din,
   input  logic        pop,
   output logic [31:0] dout,
   output logic        full,
   output logic        empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_write;
   logic        do_read;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_read  = pop & ~empty;
   // A simultaneous pop frees the head slot, so a push while full still lands.
   assign do_write = push & (~full | do_read);
   assign dout     = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/sha_nonce_result_checker.sv
// Tags double-SHA results with nonces, compares against target in two stages, queues winners.
module sha_nonce_result_checker
   import sha_nonce_result_checker_pkg::*;
#(
   parameter int unsigned PROCESSORINDEX = 0,
   parameter int unsigned NUMPROCESSORS  = 1,
   parameter int unsigned FIFODEPTH      = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   input  logic [31:0]  nonce_base,
   input  logic [255:0] target,
   input  logic         hash_valid,
   input  HashState     doublehash,
   output logic         found_valid,
   input  logic         found_ready,
   output logic [31:0]  found_nonce,
   output logic         overflow,
   output logic         busy,
   output logic         done,
   output logic [31:0]  hash_count
);

   checker_state_t state, state_next;
   logic [32:0]    nonce_ctr;
   logic [33:0]    nonce_sum;
   logic           drain_cnt;
   logic           start_ok;
   logic           run_hash;
   logic           last_hash;

   logic [HASH_W-1:0]     hash_value;
   logic [NUM_CHUNKS-1:0] lt_c, eq_c;
   logic [NUM_CHUNKS-1:0] s1_lt, s1_eq;
   logic                  s1_valid;
   logic [31:0]           s1_nonce;
   logic                  s1_win;
   logic                  s2_valid;
   logic                  s2_win;
   logic [31:0]           s2_nonce;

   logic fifo_push, fifo_pop, fifo_full, fifo_empty;

   assign start_ok  = start & ((state == ST_IDLE) | (state == ST_DONE));
   assign run_hash  = hash_valid & (state == ST_RUN) & ~abort;
   assign nonce_sum = {1'b0, nonce_ctr} + 34'(NUMPROCESSORS);
   assign last_hash = run_hash & (nonce_sum > 34'h0_FFFF_FFFF);
   assign busy      = (state == ST_RUN) | (state == ST_DRAIN);
   assign done      = (state == ST_DONE);

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (last_hash) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt) state_next = ST_DONE;
            ST_DONE:  if (start) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         drain_cnt  <= 1'b0;
         nonce_ctr  <= '0;
         hash_count <= '0;
         overflow   <= 1'b0;
      end else begin
         state     <= state_next;
         drain_cnt <= (state == ST_DRAIN) & ~abort & ~drain_cnt;
         if (start_ok & ~abort) begin
            nonce_ctr  <= {1'b0, nonce_base} + 33'(PROCESSORINDEX);
            hash_count <= '0;
            overflow   <= 1'b0;
         end else begin
            if (run_hash) begin
               nonce_ctr <= nonce_sum[32:0];
               if (hash_count != '1) hash_count <= hash_count + 1'b1;
            end
            if (fifo_push & fifo_full & ~fifo_pop) overflow <= 1'b1;
         end
      end
   end

   assign hash_value = byte_reverse(doublehash);

   always_comb begin
      lt_c = '0;
      eq_c = '0;
      for (int unsigned k = 0; k < NUM_CHUNKS; k++) begin
         lt_c[k] = hash_value[CHUNK_W*k +: CHUNK_W] <  target[CHUNK_W*k +: CHUNK_W];
         eq_c[k] = hash_value[CHUNK_W*k +: CHUNK_W] == target[CHUNK_W*k +: CHUNK_W];
      end
   end

   // Combine chunk flags from least significant upward: V <= target.
   always_comb begin
      s1_win = s1_lt[0] | s1_eq[0];
      for (int unsigned k = 1; k < NUM_CHUNKS; k++) begin
         s1_win = s1_lt[k] | (s1_eq[k] & s1_win);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_lt    <= '0;
         s1_eq    <= '0;
         s1_nonce <= '0;
         s2_valid <= 1'b0;
         s2_win   <= 1'b0;
         s2_nonce <= '0;
      end else begin
         s1_valid <= run_hash;
         s1_lt    <= lt_c;
         s1_eq    <= eq_c;
         s1_nonce <= nonce_ctr[31:0];
         s2_valid <= s1_valid & ~abort;
         s2_win   <= s1_win;
         s2_nonce <= s1_nonce;
      end
   end

   assign fifo_push   = s2_valid & s2_win & ~abort;
   assign found_valid = ~fifo_empty;
   assign fifo_pop    = found_valid & found_ready;

   nonce_result_fifo #(
      .DEPTH(FIFODEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (fifo_push),
      .din  (s2_nonce),
      .pop  (fifo_pop),
      .dout (found_nonce),
      .full (fifo_full),
      .empty(fifo_empty)
   );

endmodule

// File: doc/sha_nonce_result_checker.md
SHA_NONCE_RESULT_CHECKER -- requirements
Module: sha_nonce_result_checker

Interface
REQ-001 Parameter PROCESSORINDEX, default 0, this core's nonce offset.
REQ-002 Parameter NUMPROCESSORS, default 1, nonce stride between consecutive hashes.
REQ-003 Parameter FIFODEPTH, default 4, found-nonce FIFO entries (power of two, >=2).
REQ-004 clk  input  1  single clock; every register updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that loads nonce_base and begins a scan.
REQ-007 abort  input  1  one-cycle pulse that ends the scan and returns to IDLE.
REQ-008 nonce_base  input  32  first nonce of the scan.
REQ-009 target  input  256  acceptance threshold, held stable while running.
REQ-010 hash_valid  input  1  doublehash holds a valid result this cycle.
REQ-011 doublehash  input  HashState  second-hash output of the core, words a..h = H0..H7.
REQ-012 found_valid  output  1  FIFO non-empty.
REQ-013 found_ready  input  1  consumer accepts the head entry.
REQ-014 found_nonce  output  32  nonce at the FIFO head.
REQ-015 overflow  output  1  sticky: a winning nonce was dropped.
REQ-016 busy  output  1  state is RUN or DRAIN.
REQ-017 done  output  1  state is DONE.
REQ-018 hash_count  output  32  number of hashes checked in this scan, saturating.

Function
REQ-019 The FSM shall have four states: IDLE, RUN, DRAIN, DONE.
REQ-020 start in IDLE or DONE shall enter RUN and set nonce_ctr = nonce_base + PROCESSORINDEX (33-bit), hash_count = 0 and overflow = 0; start in RUN or DRAIN shall be ignored.
REQ-021 In RUN, each hash_valid shall tag the hash with nonce_ctr[31:0], increment hash_count, and add NUMPROCESSORS to nonce_ctr.
REQ-022 In RUN, a hash_valid whose post-increment nonce_ctr exceeds 0xFFFFFFFF shall be the last hash and shall move the FSM to DRAIN.
REQ-023 hash_valid in IDLE, DRAIN or DONE shall be ignored.
REQ-024 DRAIN shall last exactly 2 cycles, until the compare pipeline is empty, then go to DONE.
REQ-025 abort shall have priority over start and hash_valid; it shall go to IDLE, clear both compare stages, and keep the FIFO contents.
REQ-026 Hash value V = byte-reverse of {H0,H1,...,H7}, treated as a 256-bit unsigned integer; a hash wins when V <= target.
REQ-027 Compare stage 1 shall register per-64-bit-chunk lt/eq flags plus the nonce tag; stage 2 shall register the combined win flag.
REQ-028 A win with hash_valid in cycle N shall be written to the FIFO at the end of cycle N+2; found_valid shall rise in N+3 if the FIFO was empty.
REQ-029 A pop shall occur when found_valid and found_ready are both high; found_nonce shall be the head entry whenever found_valid is high and is don't-care otherwise.
REQ-030 A push and a pop in the same cycle while the FIFO is full shall both succeed with no overflow.
REQ-031 A push to a full FIFO without a simultaneous pop shall drop the new nonce and set overflow.
REQ-032 hash_count shall saturate at 0xFFFFFFFF.

Reset
REQ-033 While rst_n = 0 at a clock edge: FSM = IDLE; FIFO empty; found_valid = 0; overflow = 0; busy = 0; done = 0; hash_count = 0; both compare stages invalid; found_nonce = 0.
REQ-034 Reset mid-scan shall discard all in-flight and queued results.

Structure
REQ-035 HashState and the byte-reverse function shall come from the shared SHA package; the checker FSM state enum shall be added to that package.
REQ-036 The FIFO shall be a separate sub-module, nonce_result_fifo (32-bit data, FIFODEPTH entries, rst_n, push/pop/full/empty).
REQ-037 The block shall be placed directly on the doublehash output of the pipelined core, with hash_valid being the core's valid signal delayed to match the core's latency.

Verification
REQ-038 target = all-ones, nonce_base = 0x10, NUMPROCESSORS = 1, 3 consecutive valids -> nonces 0x10, 0x11, 0x12 popped in order, found_valid first high 3 cycles after the first valid.
REQ-039 Hash with V = target exactly, then a hash with V = target+1 -> only the first nonce is reported.
REQ-040 nonce_base = 0xFFFFFFFE, PROCESSORINDEX = 1, NUMPROCESSORS = 2 -> the first hash is tagged 0xFFFFFFFF and is the last; DRAIN lasts 2 cycles, then done = 1 and hash_count = 1.
REQ-041 FIFODEPTH = 4, found_ready = 0, 5 winning hashes -> 4 entries queued, overflow = 1; a 6th win arriving while popping on a full FIFO -> accepted with no additional loss.
REQ-042 abort one cycle after a winning hash_valid -> no FIFO push, FSM in IDLE; rst_n low during RUN with 2 queued entries -> found_valid = 0 on the next cycle.
